// File: rtl/axil_arb_pkg.sv
// ============================================================================
// Module      : axil_arb_pkg
// Description : Shared types and constants for the two-master AXI4-Lite
//               arbiter: FSM state encodings, grant type, response codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FWD  = 2'd1,
        W_RESP = 2'd2
    } write_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FWD  = 2'd1,
        R_RESP = 2'd2
    } read_state_t;

    // One bit identifies the master: 0 = S0 (HPS bridge), 1 = S1 (fabric).
    typedef logic grant_t;

    localparam grant_t     GNT_S0      = 1'b0;
    localparam grant_t     GNT_S1      = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Combinationally picks a
//               winner from req; on a tie the master not served last wins.
//               The "last served" pointer is updated when upd pulses.
// Ports       : ACLK, ARESETn  - clock, synchronous active-low reset
//               req[1:0]       - request per master
//               upd, upd_gnt   - completion strobe and the master completed
//               gnt, gnt_valid - selected master and "any request" flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import axil_arb_pkg::*;

module rr_arb2 (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] req,
    input  logic       upd,
    input  grant_t     upd_gnt,
    output grant_t     gnt,
    output logic       gnt_valid
);

    grant_t r_last;

    // Reset to "last = S1" so S0 takes the first tie.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_last <= GNT_S1;
        end else if (upd) begin
            r_last <= upd_gnt;
        end
    end

    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt = GNT_S0;
            2'b10:   gnt = GNT_S1;
            2'b11:   gnt = ~r_last;
            default: gnt = GNT_S0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axil_arb2.sv
// ============================================================================
// Module      : axil_arb2
// Description : Two-master AXI4-Lite arbiter sharing one AXI4-Lite slave.
//               Write and read paths are arbitrated independently, each with
//               its own round-robin pointer, and each holds its grant from
//               address acceptance to response handshake (one outstanding
//               write and one outstanding read at most).
// Ports       : ACLK, ARESETn       - clock, synchronous active-low reset
//               S0_* / S1_*         - AXI4-Lite slave ports for the masters
//               M_*                 - AXI4-Lite master port to the slave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import axil_arb_pkg::*;

module axil_arb2 #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // master 0
    input  logic [ADDR_WIDTH-1:0] S0_AWADDR,
    input  logic [2:0]            S0_AWPROT,
    input  logic                  S0_AWVALID,
    output logic                  S0_AWREADY,
    input  logic [31:0]           S0_WDATA,
    input  logic [3:0]            S0_WSTRB,
    input  logic                  S0_WVALID,
    output logic                  S0_WREADY,
    output logic [1:0]            S0_BRESP,
    output logic                  S0_BVALID,
    input  logic                  S0_BREADY,
    input  logic [ADDR_WIDTH-1:0] S0_ARADDR,
    input  logic [2:0]            S0_ARPROT,
    input  logic                  S0_ARVALID,
    output logic                  S0_ARREADY,
    output logic [31:0]           S0_RDATA,
    output logic [1:0]            S0_RRESP,
    output logic                  S0_RVALID,
    input  logic                  S0_RREADY,
    // master 1
    input  logic [ADDR_WIDTH-1:0] S1_AWADDR,
    input  logic [2:0]            S1_AWPROT,
    input  logic                  S1_AWVALID,
    output logic                  S1_AWREADY,
    input  logic [31:0]           S1_WDATA,
    input  logic [3:0]            S1_WSTRB,
    input  logic                  S1_WVALID,
    output logic                  S1_WREADY,
    output logic [1:0]            S1_BRESP,
    output logic                  S1_BVALID,
    input  logic                  S1_BREADY,
    input  logic [ADDR_WIDTH-1:0] S1_ARADDR,
    input  logic [2:0]            S1_ARPROT,
    input  logic                  S1_ARVALID,
    output logic                  S1_ARREADY,
    output logic [31:0]           S1_RDATA,
    output logic [1:0]            S1_RRESP,
    output logic                  S1_RVALID,
    input  logic                  S1_RREADY,
    // shared slave
    output logic [ADDR_WIDTH-1:0] M_AWADDR,
    output logic [2:0]            M_AWPROT,
    output logic                  M_AWVALID,
    input  logic                  M_AWREADY,
    output logic [31:0]           M_WDATA,
    output logic [3:0]            M_WSTRB,
    output logic                  M_WVALID,
    input  logic                  M_WREADY,
    input  logic [1:0]            M_BRESP,
    input  logic                  M_BVALID,
    output logic                  M_BREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [2:0]            M_ARPROT,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    input  logic [31:0]           M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RVALID,
    output logic                  M_RREADY
);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    write_state_t r_wstate, w_wstate_nxt;
    grant_t       r_wgnt, w_warb_gnt;
    logic         w_warb_valid;
    logic         r_aw_done, r_w_done;
    logic         w_aw_hs, w_w_hs, w_b_hs;

    // Selected-master views of the write request channels
    logic                  w_g_awvalid, w_g_wvalid, w_g_bready;
    logic [ADDR_WIDTH-1:0] w_g_awaddr;
    logic [2:0]            w_g_awprot;
    logic [31:0]           w_g_wdata;
    logic [3:0]            w_g_wstrb;

    assign w_g_awvalid = (r_wgnt == GNT_S1) ? S1_AWVALID : S0_AWVALID;
    assign w_g_awaddr  = (r_wgnt == GNT_S1) ? S1_AWADDR  : S0_AWADDR;
    assign w_g_awprot  = (r_wgnt == GNT_S1) ? S1_AWPROT  : S0_AWPROT;
    assign w_g_wvalid  = (r_wgnt == GNT_S1) ? S1_WVALID  : S0_WVALID;
    assign w_g_wdata   = (r_wgnt == GNT_S1) ? S1_WDATA   : S0_WDATA;
    assign w_g_wstrb   = (r_wgnt == GNT_S1) ? S1_WSTRB   : S0_WSTRB;
    assign w_g_bready  = (r_wgnt == GNT_S1) ? S1_BREADY  : S0_BREADY;

    assign w_aw_hs = (r_wstate == W_FWD) && w_g_awvalid && M_AWREADY && !r_aw_done;
    assign w_w_hs  = (r_wstate == W_FWD) && w_g_wvalid  && M_WREADY  && !r_w_done;
    assign w_b_hs  = (r_wstate == W_RESP) && M_BVALID && w_g_bready;

    rr_arb2 u_warb (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req       ({S1_AWVALID | S1_WVALID, S0_AWVALID | S0_WVALID}),
        .upd       (w_b_hs),
        .upd_gnt   (r_wgnt),
        .gnt       (w_warb_gnt),
        .gnt_valid (w_warb_valid)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Grant and per-channel completion flags; AW and W may finish in
    // either order, so each is tracked separately until B completes.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_wgnt    <= GNT_S0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_wstate == W_IDLE && w_warb_valid) begin
                r_wgnt <= w_warb_gnt;
            end
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_warb_valid) w_wstate_nxt = W_FWD;
            W_FWD:   if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        M_AWADDR   = '0;
        M_AWPROT   = '0;
        M_AWVALID  = 1'b0;
        M_WDATA    = '0;
        M_WSTRB    = '0;
        M_WVALID   = 1'b0;
        M_BREADY   = 1'b0;
        S0_AWREADY = 1'b0;
        S0_WREADY  = 1'b0;
        S0_BVALID  = 1'b0;
        S0_BRESP   = RESP_OKAY;
        S1_AWREADY = 1'b0;
        S1_WREADY  = 1'b0;
        S1_BVALID  = 1'b0;
        S1_BRESP   = RESP_OKAY;
        case (r_wstate)
            W_FWD: begin
                M_AWADDR  = w_g_awaddr;
                M_AWPROT  = w_g_awprot;
                M_AWVALID = w_g_awvalid && !r_aw_done;
                M_WDATA   = w_g_wdata;
                M_WSTRB   = w_g_wstrb;
                M_WVALID  = w_g_wvalid && !r_w_done;
                if (r_wgnt == GNT_S1) begin
                    S1_AWREADY = M_AWREADY && !r_aw_done;
                    S1_WREADY  = M_WREADY  && !r_w_done;
                end else begin
                    S0_AWREADY = M_AWREADY && !r_aw_done;
                    S0_WREADY  = M_WREADY  && !r_w_done;
                end
            end
            W_RESP: begin
                M_BREADY = w_g_bready;
                if (r_wgnt == GNT_S1) begin
                    S1_BVALID = M_BVALID;
                    S1_BRESP  = M_BRESP;
                end else begin
                    S0_BVALID = M_BVALID;
                    S0_BRESP  = M_BRESP;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    read_state_t r_rstate, w_rstate_nxt;
    grant_t      r_rgnt, w_rarb_gnt;
    logic        w_rarb_valid;
    logic        w_ar_hs, w_r_hs;

    logic                  w_g_arvalid, w_g_rready;
    logic [ADDR_WIDTH-1:0] w_g_araddr;
    logic [2:0]            w_g_arprot;

    assign w_g_arvalid = (r_rgnt == GNT_S1) ? S1_ARVALID : S0_ARVALID;
    assign w_g_araddr  = (r_rgnt == GNT_S1) ? S1_ARADDR  : S0_ARADDR;
    assign w_g_arprot  = (r_rgnt == GNT_S1) ? S1_ARPROT  : S0_ARPROT;
    assign w_g_rready  = (r_rgnt == GNT_S1) ? S1_RREADY  : S0_RREADY;

    assign w_ar_hs = (r_rstate == R_FWD)  && w_g_arvalid && M_ARREADY;
    assign w_r_hs  = (r_rstate == R_RESP) && M_RVALID && w_g_rready;

    rr_arb2 u_rarb (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .req       ({S1_ARVALID, S0_ARVALID}),
        .upd       (w_r_hs),
        .upd_gnt   (r_rgnt),
        .gnt       (w_rarb_gnt),
        .gnt_valid (w_rarb_valid)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rgnt <= GNT_S0;
        end else if (r_rstate == R_IDLE && w_rarb_valid) begin
            r_rgnt <= w_rarb_gnt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rarb_valid) w_rstate_nxt = R_FWD;
            R_FWD:   if (w_ar_hs) w_rstate_nxt = R_RESP;
            R_RESP:  if (w_r_hs) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        M_ARADDR   = '0;
        M_ARPROT   = '0;
        M_ARVALID  = 1'b0;
        M_RREADY   = 1'b0;
        S0_ARREADY = 1'b0;
        S0_RVALID  = 1'b0;
        S0_RDATA   = '0;
        S0_RRESP   = RESP_OKAY;
        S1_ARREADY = 1'b0;
        S1_RVALID  = 1'b0;
        S1_RDATA   = '0;
        S1_RRESP   = RESP_OKAY;
        case (r_rstate)
            R_FWD: begin
                M_ARADDR  = w_g_araddr;
                M_ARPROT  = w_g_arprot;
                M_ARVALID = w_g_arvalid;
                if (r_rgnt == GNT_S1) S1_ARREADY = M_ARREADY;
                else                  S0_ARREADY = M_ARREADY;
            end
            R_RESP: begin
                M_RREADY = w_g_rready;
                if (r_rgnt == GNT_S1) begin
                    S1_RVALID = M_RVALID;
                    S1_RDATA  = M_RDATA;
                    S1_RRESP  = M_RRESP;
                end else begin
                    S0_RVALID = M_RVALID;
                    S0_RDATA  = M_RDATA;
                    S0_RRESP  = M_RRESP;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_axil_arb2.sv
// ============================================================================
// Module      : tb_axil_arb2
// Description : Scoreboard bench for axil_arb2. Master tasks push expected
//               responses; negedge monitors pop and compare on every
//               handshake. A small register-file slave (0x00-0x14 OKAY,
//               anything else DECERR) sits on the M port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axil_arb2;

    localparam int TMO = 200;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    // master-side signals, index = master number
    logic [31:0] s_awaddr [2];
    logic [2:0]  s_awprot [2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic [31:0] s_araddr [2];
    logic [2:0]  s_arprot [2];
    logic [1:0]  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp  [2];
    logic [1:0]  s_rresp  [2];
    logic [31:0] s_rdata  [2];

    // slave side
    logic [31:0] m_awaddr, m_wdata, m_araddr, sl_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
    logic [1:0]  sl_bresp, sl_rresp;

    axil_arb2 #(.ADDR_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S0_AWADDR(s_awaddr[0]), .S0_AWPROT(s_awprot[0]), .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
        .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
        .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
        .S0_ARADDR(s_araddr[0]), .S0_ARPROT(s_arprot[0]), .S0_ARVALID(s_arvalid[0]), .S0_ARREADY(s_arready[0]),
        .S0_RDATA(s_rdata[0]), .S0_RRESP(s_rresp[0]), .S0_RVALID(s_rvalid[0]), .S0_RREADY(s_rready[0]),
        .S1_AWADDR(s_awaddr[1]), .S1_AWPROT(s_awprot[1]), .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
        .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
        .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
        .S1_ARADDR(s_araddr[1]), .S1_ARPROT(s_arprot[1]), .S1_ARVALID(s_arvalid[1]), .S1_ARREADY(s_arready[1]),
        .S1_RDATA(s_rdata[1]), .S1_RRESP(s_rresp[1]), .S1_RVALID(s_rvalid[1]), .S1_RREADY(s_rready[1]),
        .M_AWADDR(m_awaddr), .M_AWPROT(m_awprot), .M_AWVALID(m_awvalid), .M_AWREADY(sl_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WVALID(m_wvalid), .M_WREADY(sl_wready),
        .M_BRESP(sl_bresp), .M_BVALID(sl_bvalid), .M_BREADY(m_bready),
        .M_ARADDR(m_araddr), .M_ARPROT(m_arprot), .M_ARVALID(m_arvalid), .M_ARREADY(sl_arready),
        .M_RDATA(sl_rdata), .M_RRESP(sl_rresp), .M_RVALID(sl_rvalid), .M_RREADY(m_rready)
    );

    logic any_out;
    assign any_out = |{s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                       s_bresp[0], s_bresp[1], s_rresp[0], s_rresp[1], s_rdata[0], s_rdata[1],
                       m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
                       m_araddr, m_arprot, m_arvalid, m_rready};

    // ---------------- slave model: six registers at 0x00-0x14 ----------------
    logic [31:0] mem [6];
    logic        aw_have, w_have;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    function automatic bit addr_ok(input logic [31:0] a);
        return (a < 32'h18) && (a[1:0] == 2'b00);
    endfunction

    assign sl_awready = !aw_have;
    assign sl_wready  = !w_have;
    assign sl_arready = !sl_rvalid;

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_have <= 1'b0; w_have <= 1'b0; sl_bvalid <= 1'b0; sl_bresp <= 2'b00;
            sl_rvalid <= 1'b0; sl_rdata <= '0; sl_rresp <= 2'b00;
            aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
            for (int i = 0; i < 6; i++) mem[i] <= '0;
        end else begin
            if (m_awvalid && sl_awready) begin aw_have <= 1'b1; aw_addr_q <= m_awaddr; end
            if (m_wvalid && sl_wready) begin w_have <= 1'b1; w_data_q <= m_wdata; w_strb_q <= m_wstrb; end
            if (aw_have && w_have && !sl_bvalid) begin
                sl_bvalid <= 1'b1;
                aw_have <= 1'b0;
                w_have <= 1'b0;
                if (addr_ok(aw_addr_q)) begin
                    sl_bresp <= 2'b00;
                    for (int b = 0; b < 4; b++)
                        if (w_strb_q[b]) mem[aw_addr_q[4:2]][8*b +: 8] <= w_data_q[8*b +: 8];
                end else begin
                    sl_bresp <= 2'b11;
                end
            end
            if (sl_bvalid && m_bready) sl_bvalid <= 1'b0;
            if (m_arvalid && sl_arready) begin
                sl_rvalid <= 1'b1;
                sl_rdata  <= addr_ok(m_araddr) ? mem[m_araddr[4:2]] : 32'h0;
                sl_rresp  <= addr_ok(m_araddr) ? 2'b00 : 2'b11;
            end else if (sl_rvalid && m_rready) begin
                sl_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [1:0]  q_b0 [$];
    logic [1:0]  q_b1 [$];
    logic [33:0] q_r0 [$];
    logic [33:0] q_r1 [$];
    logic [31:0] q_maw [$];
    logic [35:0] q_mw  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout after %0d cycles", name, TMO);
    endtask

    always @(negedge ACLK) begin
        if (s_bvalid[0] && s_bready[0]) begin
            if (q_b0.size() == 0) chk("S0 unexpected B", 64'(s_bvalid[0]), 0);
            else                  chk("S0 BRESP", 64'(s_bresp[0]), 64'(q_b0.pop_front()));
        end
        if (s_bvalid[1] && s_bready[1]) begin
            if (q_b1.size() == 0) chk("S1 unexpected B", 64'(s_bvalid[1]), 0);
            else                  chk("S1 BRESP", 64'(s_bresp[1]), 64'(q_b1.pop_front()));
        end
        if (s_rvalid[0] && s_rready[0]) begin
            if (q_r0.size() == 0) chk("S0 unexpected R", 64'(s_rvalid[0]), 0);
            else                  chk("S0 RRESP/RDATA", 64'({s_rresp[0], s_rdata[0]}), 64'(q_r0.pop_front()));
        end
        if (s_rvalid[1] && s_rready[1]) begin
            if (q_r1.size() == 0) chk("S1 unexpected R", 64'(s_rvalid[1]), 0);
            else                  chk("S1 RRESP/RDATA", 64'({s_rresp[1], s_rdata[1]}), 64'(q_r1.pop_front()));
        end
        // slave-side order: reveals which master held the write grant
        if (m_awvalid && sl_awready) begin
            if (q_maw.size() == 0) chk("M unexpected AW", 64'(m_awvalid), 0);
            else                   chk("M AWADDR order", 64'(m_awaddr), 64'(q_maw.pop_front()));
        end
        if (m_wvalid && sl_wready) begin
            if (q_mw.size() == 0) chk("M unexpected W", 64'(m_wvalid), 0);
            else                  chk("M WSTRB/WDATA order", 64'({m_wstrb, m_wdata}), 64'(q_mw.pop_front()));
        end
    end

    // ---------------- master tasks ----------------
    task automatic axi_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                             input int w_lead, input logic [1:0] exp_resp, input bit no_resp);
        int cyc;
        bit awd, wd, bd;
        if (!no_resp) begin
            if (m == 0) q_b0.push_back(exp_resp);
            else        q_b1.push_back(exp_resp);
        end
        s_bready[m] = !no_resp;
        s_awaddr[m] = addr;
        s_wdata[m]  = data;
        s_wstrb[m]  = 4'hF;
        cyc = 0; awd = 0; wd = 0;
        while (!(awd && wd)) begin
            s_awvalid[m] = !awd && (cyc >= w_lead);
            s_wvalid[m]  = !wd;
            @(negedge ACLK);
            if (s_awvalid[m] && s_awready[m]) awd = 1;
            if (s_wvalid[m] && s_wready[m])   wd = 1;
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > TMO) begin tmo("write AW/W accept"); break; end
        end
        s_awvalid[m] = 1'b0;
        s_wvalid[m]  = 1'b0;
        if (!no_resp) begin
            cyc = 0; bd = 0;
            while (!bd) begin
                @(negedge ACLK);
                if (s_bvalid[m]) bd = 1;
                @(posedge ACLK); #1;
                cyc++;
                if (cyc > TMO) begin tmo("write B"); break; end
            end
        end
    endtask

    task automatic axi_read(input int m, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int cyc;
        bit done;
        if (m == 0) q_r0.push_back({exp_resp, exp_data});
        else        q_r1.push_back({exp_resp, exp_data});
        s_araddr[m]  = addr;
        s_arvalid[m] = 1'b1;
        cyc = 0; done = 0;
        while (!done) begin
            @(negedge ACLK);
            if (s_arready[m]) done = 1;
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > TMO) begin tmo("read AR accept"); break; end
        end
        s_arvalid[m] = 1'b0;
        cyc = 0; done = 0;
        while (!done) begin
            @(negedge ACLK);
            if (s_rvalid[m]) done = 1;
            @(posedge ACLK); #1;
            cyc++;
            if (cyc > TMO) begin tmo("read R"); break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int m = 0; m < 2; m++) begin
            s_awaddr[m] = '0; s_awprot[m] = '0; s_wdata[m] = '0; s_wstrb[m] = '0;
            s_araddr[m] = '0; s_arprot[m] = '0;
        end
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        s_bready = 2'b11; s_rready = 2'b11;

        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        chk("reset: all outputs zero", 64'(any_out), 0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // 1: single S0 write, arbitration adds one cycle, S1 held off
        q_maw.push_back(32'h08); q_mw.push_back({4'hF, 32'h5});
        fork
            axi_write(0, 32'h08, 32'h5, 0, 2'b00, 0);
            begin
                @(negedge ACLK);
                chk("t1 M_AWVALID in arb cycle", 64'(m_awvalid), 0);
                chk("t1 S0_AWREADY in arb cycle", 64'(s_awready[0]), 0);
                @(negedge ACLK);
                chk("t1 M_AWVALID/WVALID next cycle", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
                chk("t1 M addr/data/strb", 64'({m_wstrb, m_awaddr[7:0], m_wdata}), 64'({4'hF, 8'h08, 32'h5}));
                chk("t1 S1 readies", 64'({s_awready[1], s_wready[1], s_arready[1]}), 0);
            end
        join
        repeat (2) @(posedge ACLK); #1;

        // 2: simultaneous writes after the S0 pointer update -> tie; last is S0
        //    from test 1, so... S1 would win here. Make the tie fresh by resetting.
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        q_maw.push_back(32'h00); q_mw.push_back({4'hF, 32'h1});
        q_maw.push_back(32'h04); q_mw.push_back({4'hF, 32'h2});
        fork
            axi_write(0, 32'h00, 32'h1, 0, 2'b00, 0);
            axi_write(1, 32'h04, 32'h2, 0, 2'b00, 0);
        join
        axi_read(0, 32'h00, 32'h1, 2'b00);
        axi_read(1, 32'h04, 32'h2, 2'b00);

        // 3: 8 writes each, continuous; write pointer is S1 -> S0 first, alternate
        for (int i = 0; i < 8; i++) begin
            q_maw.push_back(32'h00); q_mw.push_back({4'hF, 32'h100 + 32'(i)});
            q_maw.push_back(32'h04); q_mw.push_back({4'hF, 32'h200 + 32'(i)});
        end
        fork
            for (int i = 0; i < 8; i++) axi_write(0, 32'h00, 32'h100 + 32'(i), 0, 2'b00, 0);
            for (int j = 0; j < 8; j++) axi_write(1, 32'h04, 32'h200 + 32'(j), 0, 2'b00, 0);
        join

        // 4: S1 W two cycles ahead of AW, out-of-range address -> DECERR
        q_maw.push_back(32'h18); q_mw.push_back({4'hF, 32'h33});
        axi_write(1, 32'h18, 32'h33, 2, 2'b11, 0);

        // 5: S0 write and S1 read in parallel; 0x08 still holds 0x5
        //    (slave registers were cleared by the reset before test 2, so
        //    rewrite 0x08 first)
        q_maw.push_back(32'h08); q_mw.push_back({4'hF, 32'h5});
        axi_write(0, 32'h08, 32'h5, 0, 2'b00, 0);
        q_maw.push_back(32'h10); q_mw.push_back({4'hF, 32'hA5});
        fork
            axi_write(0, 32'h10, 32'hA5, 0, 2'b00, 0);
            axi_read(1, 32'h08, 32'h5, 2'b00);
        join

        // 6: reset while stuck in W_RESP with BREADY low
        q_maw.push_back(32'h14); q_mw.push_back({4'hF, 32'h99});
        axi_write(0, 32'h14, 32'h99, 0, 2'b00, 1);
        repeat (2) @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("t6 S0_BVALID pending", 64'(s_bvalid[0]), 1);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        s_bready[0] = 1'b1;
        @(negedge ACLK);
        chk("t6 all outputs zero after reset", 64'(any_out), 0);
        @(posedge ACLK); #1;
        q_maw.push_back(32'h0C); q_mw.push_back({4'hF, 32'h77});
        axi_write(1, 32'h0C, 32'h77, 0, 2'b00, 0);
        axi_read(1, 32'h0C, 32'h77, 2'b00);

        repeat (4) @(posedge ACLK); #1;
        chk("scoreboard drained",
            64'(q_b0.size() + q_b1.size() + q_r0.size() + q_r1.size() + q_maw.size() + q_mw.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
